// File: rtl/ddr_arbiter.sv
// ddr_arbiter: two-port arbiter in front of a single DDR channel.
//
// Each requester raises read or write and holds addr/wdata until it sees its
// resp pulse. The granted port's live request is forwarded straight to the
// DDR side. The DDR completion is routed straight back to that port in the
// same cycle. A one-cycle RELEASE gap follows every completion, giving the
// finished requester time to drop its request before the next arbitration.
//
// Parameters
//   timeout_cycles : GRANT cycles without ddr_arb_resp before arb_timeout sets
//   WORD_W         : width of rvga_word (line address)
//   LINE_W         : width of rvga_cacheline (data line)
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   req{0,1}_arb_addr/read/write/wdata : requester inputs
//   arb_req{0,1}_rdata/resp       : read line and completion pulse per port
//   arb_ddr_addr/read/write/wdata : request towards DDR
//   ddr_arb_rdata/resp            : DDR read line and completion
//   arb_timeout                   : sticky flag, DDR took too long
//
// Build option
//   DDR_ARB_RR_EN defined   : round-robin on contention (last_grant register)
//   DDR_ARB_RR_EN undefined : fixed priority, port 0 wins contention
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | sample requests, pick a port
// GRANT0  | port 0 owns the DDR channel, waiting for ddr_arb_resp
// GRANT1  | port 1 owns the DDR channel, waiting for ddr_arb_resp
// RELEASE | one dead cycle so the finished requester can deassert

module ddr_arbiter #(
  parameter int timeout_cycles = 1024,
  parameter int WORD_W         = 32,
  parameter int LINE_W         = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [WORD_W-1:0] req0_arb_addr,
  input  logic              req0_arb_read,
  input  logic              req0_arb_write,
  input  logic [LINE_W-1:0] req0_arb_wdata,
  output logic [LINE_W-1:0] arb_req0_rdata,
  output logic              arb_req0_resp,

  input  logic [WORD_W-1:0] req1_arb_addr,
  input  logic              req1_arb_read,
  input  logic              req1_arb_write,
  input  logic [LINE_W-1:0] req1_arb_wdata,
  output logic [LINE_W-1:0] arb_req1_rdata,
  output logic              arb_req1_resp,

  output logic [WORD_W-1:0] arb_ddr_addr,
  output logic              arb_ddr_read,
  output logic              arb_ddr_write,
  output logic [LINE_W-1:0] arb_ddr_wdata,
  input  logic [LINE_W-1:0] ddr_arb_rdata,
  input  logic              ddr_arb_resp,

  output logic              arb_timeout
);

  // timeout_cycles is expected to be at least 1
  localparam int CNT_W = (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(timeout_cycles);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_q;
`ifdef DDR_ARB_RR_EN
  logic               last_grant_q;
`endif

  logic req0_any;
  logic req1_any;
  logic grant1_d;   // port chosen when leaving IDLE: 1 = port 1, 0 = port 0
  logic g0;
  logic g1;

  assign req0_any = req0_arb_read | req0_arb_write;
  assign req1_any = req1_arb_read | req1_arb_write;

  always_comb begin
    grant1_d = 1'b0;
`ifdef DDR_ARB_RR_EN
    // On contention the port that was not granted last time wins
    grant1_d = req1_any & (~req0_any | ~last_grant_q);
`else
    grant1_d = req1_any & ~req0_any;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef DDR_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_any | req1_any) begin
            state_q <= grant1_d ? GRANT1 : GRANT0;
            cnt_q   <= '0;
`ifdef DDR_ARB_RR_EN
            last_grant_q <= grant1_d;
`endif
          end
        end
        GRANT0, GRANT1: begin
          if (ddr_arb_resp) begin
            state_q <= RELEASE;
          end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            // flag follows the counter reaching timeout_cycles; never cleared
            // except by reset, and the transaction keeps waiting
            if (cnt_q == CNT_LAST) timeout_q <= 1'b1;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset also masks outputs combinationally so nothing leaks while rst is high
  assign g0 = (state_q == GRANT0) & ~rst;
  assign g1 = (state_q == GRANT1) & ~rst;

  always_comb begin
    arb_ddr_addr  = '0;
    arb_ddr_read  = 1'b0;
    arb_ddr_write = 1'b0;
    arb_ddr_wdata = '0;
    if (g0) begin
      arb_ddr_addr  = req0_arb_addr;
      arb_ddr_write = req0_arb_write;
      // simultaneous read+write is treated as a write
      arb_ddr_read  = req0_arb_read & ~req0_arb_write;
      arb_ddr_wdata = req0_arb_wdata;
    end else if (g1) begin
      arb_ddr_addr  = req1_arb_addr;
      arb_ddr_write = req1_arb_write;
      arb_ddr_read  = req1_arb_read & ~req1_arb_write;
      arb_ddr_wdata = req1_arb_wdata;
    end
  end

  assign arb_req0_rdata = g0 ? ddr_arb_rdata : '0;
  assign arb_req1_rdata = g1 ? ddr_arb_rdata : '0;
  assign arb_req0_resp  = g0 & ddr_arb_resp;
  assign arb_req1_resp  = g1 & ddr_arb_resp;
  assign arb_timeout    = timeout_q & ~rst;

endmodule

// File: tb/tb_ddr_arbiter.sv
module tb_ddr_arbiter;
  localparam int W   = 32;
  localparam int L   = 256;
  localparam int LAT = 5;
  localparam int TO  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] req0_arb_addr,  req1_arb_addr;
  logic         req0_arb_read,  req1_arb_read;
  logic         req0_arb_write, req1_arb_write;
  logic [L-1:0] req0_arb_wdata, req1_arb_wdata;
  logic [L-1:0] arb_req0_rdata, arb_req1_rdata;
  logic         arb_req0_resp,  arb_req1_resp;
  logic [W-1:0] arb_ddr_addr;
  logic         arb_ddr_read, arb_ddr_write;
  logic [L-1:0] arb_ddr_wdata;
  logic [L-1:0] ddr_arb_rdata;
  logic         ddr_arb_resp;
  logic         arb_timeout;

  ddr_arbiter #(.timeout_cycles(TO), .WORD_W(W), .LINE_W(L)) dut (
    .clk(clk), .rst(rst),
    .req0_arb_addr(req0_arb_addr), .req0_arb_read(req0_arb_read),
    .req0_arb_write(req0_arb_write), .req0_arb_wdata(req0_arb_wdata),
    .arb_req0_rdata(arb_req0_rdata), .arb_req0_resp(arb_req0_resp),
    .req1_arb_addr(req1_arb_addr), .req1_arb_read(req1_arb_read),
    .req1_arb_write(req1_arb_write), .req1_arb_wdata(req1_arb_wdata),
    .arb_req1_rdata(arb_req1_rdata), .arb_req1_resp(arb_req1_resp),
    .arb_ddr_addr(arb_ddr_addr), .arb_ddr_read(arb_ddr_read),
    .arb_ddr_write(arb_ddr_write), .arb_ddr_wdata(arb_ddr_wdata),
    .ddr_arb_rdata(ddr_arb_rdata), .ddr_arb_resp(ddr_arb_resp),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic [W-1:0] addr;
  } sb_t;

  typedef struct {
    int           port;
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [L-1:0] wdata;
    logic         exp_rd;
    logic         exp_wr;
  } vec_t;

  sb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ddr_cnt = 0;
  bit  ddr_mute = 1'b0;
  bit  ddr_force = 1'b0;
  int  resp_cnt[2] = '{0, 0};
  int  rereq_left[2] = '{0, 0};
  bit  rereq_pend[2] = '{1'b0, 1'b0};
  int  quiet_port = -1;
  bit  quiet_bad = 1'b0;

  task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic rd, input logic wr,
                         input logic [W-1:0] a, input logic [L-1:0] wd);
    if (p == 0) begin
      req0_arb_read = rd; req0_arb_write = wr; req0_arb_addr = a; req0_arb_wdata = wd;
    end else begin
      req1_arb_read = rd; req1_arb_write = wr; req1_arb_addr = a; req1_arb_wdata = wd;
    end
  endtask

  function automatic logic any_out();
    return arb_ddr_read | arb_ddr_write | (|arb_ddr_addr) | (|arb_ddr_wdata) |
           arb_req0_resp | arb_req1_resp | (|arb_req0_rdata) | (|arb_req1_rdata) |
           arb_timeout;
  endfunction

  // One clock: requesters re-arm, DDR model reacts, outputs sampled,
  // completions popped from the scoreboard and finished requests dropped.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (rereq_pend[n]) begin
        rereq_pend[n] = 1'b0;
        if (n == 0) req0_arb_read = 1'b1; else req1_arb_read = 1'b1;
      end
    end
    if (!ddr_mute && (arb_ddr_read || arb_ddr_write)) ddr_cnt++;
    else ddr_cnt = 0;
    ddr_arb_resp  = (ddr_cnt == LAT) || ddr_force;
    ddr_arb_rdata = {8{arb_ddr_addr}};
    #1;
    if (arb_req0_resp && arb_req1_resp) chk("resp_both_ports", 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) begin
      logic         r;
      logic [L-1:0] rd;
      r  = (n == 0) ? arb_req0_resp  : arb_req1_resp;
      rd = (n == 0) ? arb_req0_rdata : arb_req1_rdata;
      if (r) begin
        resp_cnt[n]++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_resp_port", n, 99);
        end else begin
          e = exp_q.pop_front();
          chk("sb_port", n, e.port);
          chk("sb_rdata", rd, {8{e.addr}});
        end
        if (n == 0) begin req0_arb_read = 1'b0; req0_arb_write = 1'b0; end
        else        begin req1_arb_read = 1'b0; req1_arb_write = 1'b0; end
        if (rereq_left[n] > 0) begin
          rereq_left[n]--;
          rereq_pend[n] = 1'b1;
        end
      end
    end
    if (quiet_port == 0 && (arb_req0_resp || (|arb_req0_rdata))) quiet_bad = 1'b1;
    if (quiet_port == 1 && (arb_req1_resp || (|arb_req1_rdata))) quiet_bad = 1'b1;
  endtask

  task automatic wait_resp(input int n, input int limit, output int nsteps);
    int start;
    start  = resp_cnt[n];
    nsteps = 0;
    while (resp_cnt[n] == start && nsteps < limit) begin
      step();
      nsteps++;
    end
    if (resp_cnt[n] == start) begin
      checks++;
      errors++;
      $display("FAIL wait_resp_port%0d: no resp within %0d cycles", n, limit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n, start, k;
    bit   gap_bad, lat_bad;

    vecs[0] = '{0, 1'b1, 1'b0, 32'h40,  '0,                 1'b1, 1'b0};
    vecs[1] = '{1, 1'b1, 1'b1, 32'h80,  {16{16'hAAAA}},     1'b0, 1'b1};
    vecs[2] = '{1, 1'b1, 1'b0, 32'h300, {8{32'h0BAD_F00D}}, 1'b1, 1'b0};
    vecs[3] = '{0, 1'b0, 1'b1, 32'h44,  {8{32'h5555_1234}}, 1'b0, 1'b1};

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    ddr_arb_resp  = 1'b0;
    ddr_arb_rdata = '0;

    // reset state
    repeat (3) step();
    chk("rst_outputs", any_out(), 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_outputs", any_out(), 1'b0);

    // contention: finished port re-requests so every round is contended
    repeat (2) step();
`ifdef DDR_ARB_RR_EN
    exp_q.push_back('{0, 32'h100}); exp_q.push_back('{1, 32'h200});
    exp_q.push_back('{0, 32'h100}); exp_q.push_back('{1, 32'h200});
    exp_q.push_back('{0, 32'h100}); exp_q.push_back('{1, 32'h200});
`else
    exp_q.push_back('{0, 32'h100}); exp_q.push_back('{0, 32'h100});
    exp_q.push_back('{0, 32'h100}); exp_q.push_back('{1, 32'h200});
    exp_q.push_back('{1, 32'h200}); exp_q.push_back('{1, 32'h200});
`endif
    rereq_left[0] = 2;
    rereq_left[1] = 2;
    set_req(0, 1'b1, 1'b0, 32'h100, '0);
    set_req(1, 1'b1, 1'b0, 32'h200, '0);
    start = resp_cnt[0] + resp_cnt[1];
    k = 0;
    while ((resp_cnt[0] + resp_cnt[1] - start) < 6 && k < 200) begin
      step();
      k++;
    end
    chk("contention_resp_count", resp_cnt[0] + resp_cnt[1] - start, 6);
    chk("contention_sb_drained", exp_q.size(), 0);
    repeat (3) step();

    // single transactions from the vector table
    start = resp_cnt[0] + resp_cnt[1];
    for (int i = 0; i < 4; i++) begin
      quiet_port = 1 - vecs[i].port;
      quiet_bad  = 1'b0;
      repeat (2) step();
      set_req(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      exp_q.push_back('{vecs[i].port, vecs[i].addr});
      step();
      chk("vec_ddr_read",  arb_ddr_read,  vecs[i].exp_rd);
      chk("vec_ddr_write", arb_ddr_write, vecs[i].exp_wr);
      chk("vec_ddr_addr",  arb_ddr_addr,  vecs[i].addr);
      chk("vec_ddr_wdata", arb_ddr_wdata, vecs[i].wdata);
      wait_resp(vecs[i].port, 20, n);
      chk("vec_resp_latency", n, LAT - 1);
      step();
      chk("vec_release_quiet", any_out(), 1'b0);
      step();
      chk("vec_idle_quiet", any_out(), 1'b0);
      chk("vec_other_port_quiet", quiet_bad, 1'b0);
    end
    quiet_port = -1;
    chk("vec_resp_pulses", resp_cnt[0] + resp_cnt[1] - start, 4);

    // a request dropped before being granted is not served
    start = resp_cnt[1];
    set_req(0, 1'b1, 1'b0, 32'h900, '0);
    exp_q.push_back('{0, 32'h900});
    step();
    set_req(1, 1'b1, 1'b0, 32'h700, '0);
    repeat (2) step();
    set_req(1, 1'b0, 1'b0, 32'h700, '0);
    wait_resp(0, 20, n);
    repeat (6) step();
    chk("dropped_req_not_granted", resp_cnt[1] - start, 0);

    // timeout: DDR silent, flag after 8 grant cycles, sticky until reset
    repeat (2) step();
    ddr_mute = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h500, '0);
    exp_q.push_back('{0, 32'h500});
    for (int g = 1; g <= TO; g++) begin
      step();
      if (g == TO) chk("timeout_before_limit", arb_timeout, 1'b0);
    end
    step();
    chk("timeout_set", arb_timeout, 1'b1);
    repeat (5) step();
    chk("timeout_held", arb_timeout, 1'b1);
    chk("timeout_still_waiting", arb_ddr_read, 1'b1);
    ddr_mute = 1'b0;
    wait_resp(0, 20, n);
    repeat (3) step();
    chk("timeout_sticky_after_resp", arb_timeout, 1'b1);
    rst = 1'b1;
    #1;
    chk("timeout_masked_in_rst", arb_timeout, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("timeout_cleared_by_rst", arb_timeout, 1'b0);

    // reset two cycles into GRANT0, then a late DDR resp
    repeat (2) step();
    start = resp_cnt[0];
    set_req(0, 1'b1, 1'b0, 32'h600, '0);
    step();
    step();
    chk("grant_before_rst", arb_ddr_read, 1'b1);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h600, '0);
    step();
    chk("rst_mid_grant_outputs", any_out(), 1'b0);
    rst = 1'b0;
    ddr_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("late_resp_ignored", arb_req0_resp, 1'b0);
    end
    ddr_force = 1'b0;
    step();
    chk("late_resp_no_pulse", resp_cnt[0] - start, 0);

    // stream: 256 reads from port 0 with identity-data DDR
    repeat (2) step();
    start   = resp_cnt[0];
    gap_bad = 1'b0;
    lat_bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      set_req(0, 1'b1, 1'b0, W'(i * 4), '0);
      exp_q.push_back('{0, W'(i * 4)});
      wait_resp(0, 20, n);
      if (n != ((i == 0) ? LAT : LAT + 1)) lat_bad = 1'b1;
      step();
      if (arb_ddr_read || arb_ddr_write) gap_bad = 1'b1;
    end
    chk("stream_resp_count", resp_cnt[0] - start, 256);
    chk("stream_latency", lat_bad, 1'b0);
    chk("stream_release_gap", gap_bad, 1'b0);
    repeat (3) step();
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
